sipo_stream_buf: RTL

- Parametrised serial-in/parallel-out buffer. It assembles a serial bit stream into WORD_W-bit words and stores them in an internal DEPTH-entry FIFO.
- Words are presented on a valid/ready parallel output port.
- Compared with the fixed 32-bit/256B buffer generation, it adds:
  - configurable word width, depth and bit order;
  - backpressure on the serial side;
  - a flush request that commits a zero-padded partial word.
- Sits between the scan/serial capture path and the parallel consumer (memory/bus side).

---
 rtl/sipo_stream_buf.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sipo_stream_buf.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_stream_buf
//  Purpose  : Serial-in / parallel-out stream buffer. Assembles a serial bit
//             stream into WORD_W-bit words and queues them in a DEPTH-entry
//             FIFO that drains over a valid/ready parallel port. A held
//             flush request commits a zero-padded partial word.
//
//  Ports    : clk        - clock
//             reset      - synchronous, active-high reset
//             sin_val    - serial bit valid
//             sin_bit    - serial data bit
//             sin_rdy    - serial bit accepted when sin_val && sin_rdy
//             flush_req  - level request to commit a partial word
//             flush_ack  - one-cycle pulse on the edge the flush completes
//             out_val    - FIFO not empty
//             out_data   - head word of the FIFO (combinational read)
//             out_rdy    - consumer pops the head when out_val && out_rdy
//             count      - number of stored words
//             bitcnt     - bits held in the shift register (0..WORD_W-1)
//             full       - count == DEPTH
//
//  Revision : 1.0 - initial release
// ============================================================================
module sipo_stream_buf #(
    parameter int WORD_W    = 32,
    parameter int DEPTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sin_val,
    input  logic                        sin_bit,
    output logic                        sin_rdy,
    input  logic                        flush_req,
    output logic                        flush_ack,
    output logic                        out_val,
    output logic [WORD_W-1:0]           out_data,
    input  logic                        out_rdy,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic [$clog2(WORD_W+1)-1:0] bitcnt,
    output logic                        full
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_BIT_W = $clog2(WORD_W + 1);
    localparam int c_PTR_W = $clog2(DEPTH);

    localparam logic [c_BIT_W-1:0] c_WORD_BITS = c_BIT_W'(WORD_W);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(WORD_W - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    // Flush state machine
    localparam logic [0:0] c_S_FILL       = 1'b0;
    localparam logic [0:0] c_S_FLUSH_WAIT = 1'b1;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [WORD_W-1:0]  r_mem [DEPTH];
    logic [WORD_W-1:0]  r_shift;
    logic [c_BIT_W-1:0] r_bitcnt;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_full;
    logic [0:0]         r_state;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic               w_in_wait;
    logic               w_sin_rdy;
    logic               w_accept;
    logic [WORD_W-1:0]  w_shift_acc;
    logic [WORD_W-1:0]  w_shift_cur;
    logic [c_BIT_W-1:0] w_nbits;
    logic [c_BIT_W-1:0] w_pad_sh;
    logic [WORD_W-1:0]  w_padded;
    logic               w_word_done;
    logic               w_fill_req;
    logic               w_flush_empty;
    logic               w_flush_commit_fill;
    logic               w_flush_park;
    logic               w_flush_commit_wait;
    logic               w_pad_commit;
    logic               w_push;
    logic               w_pop;
    logic [WORD_W-1:0]  w_push_data;
    logic [c_CNT_W-1:0] w_count_nxt;

    assign w_in_wait = (r_state == c_S_FLUSH_WAIT);

    // Only the word-completing bit is stalled while full; partial bits keep
    // flowing. Built purely from registered state, so no path from out_rdy.
    assign w_sin_rdy = !w_in_wait && !(r_full && (r_bitcnt == c_LAST_BIT));
    assign w_accept  = sin_val && w_sin_rdy;

    // Shift register contents including this cycle's bit, if any. A flush
    // commit in the same cycle pads this value, so the new bit goes in first.
    assign w_shift_cur = w_accept ? w_shift_acc : r_shift;
    assign w_nbits     = r_bitcnt + (w_accept ? c_BIT_W'(1) : c_BIT_W'(0));
    assign w_word_done = w_accept && (r_bitcnt == c_LAST_BIT);

    // Distance the received bits must travel to reach their padded position.
    // Only used for 1..WORD_W-1 bits, so the shift is always 1..WORD_W-1.
    assign w_pad_sh = c_WORD_BITS - w_nbits;

    generate
        if (MSB_FIRST) begin : g_msb_first
            // First bit ends up in the MSB: shift left, new bit at bit 0.
            // Padding moves the received bits up and fills zeros below.
            assign w_shift_acc = {r_shift[WORD_W-2:0], sin_bit};
            assign w_padded    = w_shift_cur << w_pad_sh;
        end else begin : g_lsb_first
            // First bit ends up in the LSB: shift right, new bit at the top.
            // Padding moves the received bits down and fills zeros above.
            assign w_shift_acc = {sin_bit, r_shift[WORD_W-1:1]};
            assign w_padded    = w_shift_cur >> w_pad_sh;
        end
    endgenerate

    // Flush decisions use the bit count from before this cycle's bit.
    assign w_fill_req          = !w_in_wait && flush_req;
    assign w_flush_empty       = w_fill_req && (r_bitcnt == '0);
    // A word-completing bit already commits a full word; no extra empty one.
    assign w_flush_commit_fill = w_fill_req && (r_bitcnt != '0) && !w_word_done && !r_full;
    // A full FIFO can never coincide with a word-completing bit (stalled).
    assign w_flush_park        = w_fill_req && (r_bitcnt != '0) && r_full;
    assign w_flush_commit_wait = w_in_wait && !r_full;
    assign w_pad_commit        = w_flush_commit_fill || w_flush_commit_wait;

    // Neither push source can fire while full: the completing bit is stalled
    // and both padded commits require !r_full.
    assign w_push      = w_word_done || w_pad_commit;
    assign w_push_data = w_word_done ? w_shift_cur : w_padded;
    assign w_pop       = (r_count != '0) && out_rdy;

    assign flush_ack = w_flush_empty || (w_fill_req && w_word_done) || w_pad_commit;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Control and shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_state  <= c_S_FILL;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH_CNT);

            if (w_push) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end else if (w_accept) begin
                r_shift  <= w_shift_acc;
                r_bitcnt <= w_nbits;
            end

            case (r_state)
                c_S_FILL: begin
                    if (w_flush_park) begin
                        r_state <= c_S_FLUSH_WAIT;
                    end
                end
                c_S_FLUSH_WAIT: begin
                    if (w_flush_commit_wait) begin
                        r_state <= c_S_FILL;
                    end
                end
                default: r_state <= c_S_FILL;
            endcase
        end
    end

    // FIFO array carries no reset; out_data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sin_rdy  = w_sin_rdy;
    assign out_val  = (r_count != '0);
    assign out_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign bitcnt   = r_bitcnt;
    assign full     = r_full;

endmodule
`default_nettype wire
